ball_motion: RTL and testbench
==============================

// Module: ball_motion
// PURPOSE
// - Upstream of the per-ball intensity lookup: owns the positions of NUM_BALLS balls and moves them once per frame.
// - Runs synchronously in the pixel clock domain; the frame tick is the falling edge of v_sync, sampled with clk_50mhz.
// - Updates one ball per cycle into shadow registers, then commits all positions at once.
// - Result: the lookup stages never see a mix of old and new positions inside one frame.
// PARAMETERS
// - NUM_BALLS     2    number of balls (1..8)
// - SCREEN_WIDTH  800  visible width, pixels
// - SCREEN_HEIGHT 600  visible height, lines
// - BALL_DIM      64   ball window edge; MAX_X = SCREEN_WIDTH-BALL_DIM (736), MAX_Y = SCREEN_HEIGHT-BALL_DIM (536)
// - SPEED         5    pixels moved per frame per axis
// - START_X       150  reset x of ball 0; ball i starts at START_X + i*START_STEP
// - START_Y       100  reset y of every ball
// - START_STEP    200  x spacing between balls at reset
// PORTS
// - clk_50mhz    in   1            pixel clock
// - reset_n      in   1            async active-low reset
// - v_sync       in   1            active-low vertical sync from the timing generator (same clock domain)
// - ball_x       out  10*NUM_BALLS committed x, ball i at [10*i+9:10*i]
// - ball_y       out  10*NUM_BALLS committed y, same packing
// - busy         out  1            high while the FSM is in UPDATE or COMMIT
// - frame_done   out  1            1-cycle pulse when new positions are committed
// - missed_tick  out  1            1-cycle pulse when a tick arrives while busy
// BEHAVIOUR
// - Reset (async assert, sync release):
//   - ball_x/ball_y and shadows = start positions.
//   - vx=1 for all balls; vy=1 for even i, vy=0 for odd i (1=increasing).
//   - busy=0, frame_done=0, missed_tick=0, FSM=IDLE, v_sync delay reg=1.
// - Tick: v_sync_q==1 && v_sync==0 (v_sync_q = v_sync delayed one clock), seen at cycle T.
// - FSM states: IDLE, UPDATE, COMMIT.
//   - IDLE -> UPDATE on tick; index idx cleared to 0.
//   - UPDATE: shadow of ball idx updated at cycle T+1+idx; idx increments.
//     After idx==NUM_BALLS-1 -> COMMIT.
//   - COMMIT: ball_x/ball_y <= shadows; frame_done=1; -> IDLE.
//   - New outputs are visible from cycle T+2+NUM_BALLS.
// - busy=1 in UPDATE and COMMIT only. A tick while busy is dropped and pulses missed_tick; FSM progress is unaffected.
// - Per-axis update (x shown; y identical with vy, MAX_Y). Arithmetic in 11 bits, no 10-bit wrap allowed:
//   - vx=1 and x+SPEED >= MAX_X: x <= MAX_X, vx <= 0.
//   - vx=0 and x <= SPEED: x <= 0, vx <= 1.
//   - otherwise x <= x +/- SPEED.
// - The velocity flip and the clamp happen in the same update. x and y are independent, so a corner hit flips both.
// - Outputs change only in COMMIT or on reset; they are stable for the rest of the frame.
// - reset_n low mid-UPDATE/COMMIT: immediate return to reset values; the partial frame is discarded and no frame_done is issued.
// CONFIGURATION
// - BALL_MOTION_PAUSE_EN defined:
//   - adds input pause (1 bit).
//   - While pause=1, ticks are ignored in IDLE: no UPDATE and no missed_tick. Positions are held.
//   - pause has no effect on an update already in progress.
// - Not defined: no pause port; every tick in IDLE starts an update.
// TESTING
// - Reset, NUM_BALLS=2 -> ball_x={350,150}, ball_y={100,100}; busy=0; no pulses.
// - One v_sync fall at cycle T -> busy=1 at T+1.
//   - frame_done at T+3; ball0=(155,105), ball1=(355,95); busy=0 at T+4.
// - 118 ticks -> ball0 x=736 (vx cleared).
//   - tick 119 -> x=731.
//   - tick 88 -> ball0 y=536; tick 89 -> y=531.
// - Ball1 y after 19 ticks = 5; tick 20 -> y=0; tick 21 -> y=5.
// - Second v_sync fall 1 cycle after the first -> missed_tick pulse.
//   - Exactly one frame_done; positions advanced by a single step.
// - reset_n low at T+2 -> outputs at start values the same cycle, no frame_done.
//   - With BALL_MOTION_PAUSE_EN and pause=1: 5 ticks leave positions unchanged.

Source files
------------

// File: rtl/ball_motion_if.sv
// rtl/ball_motion_if.sv - signal bundle between the timing generator and ball_motion (BALL_MOTION_PAUSE_EN adds pause)
interface ball_motion_if #(
    parameter int NUM_BALLS = 2
);
    logic                    v_sync;
`ifdef BALL_MOTION_PAUSE_EN
    logic                    pause;
`endif
    logic [10*NUM_BALLS-1:0] ball_x;
    logic [10*NUM_BALLS-1:0] ball_y;
    logic                    busy;
    logic                    frame_done;
    logic                    missed_tick;

`ifdef BALL_MOTION_PAUSE_EN
    modport master (output v_sync, output pause,
                    input ball_x, input ball_y, input busy, input frame_done, input missed_tick);
    modport slave  (input v_sync, input pause,
                    output ball_x, output ball_y, output busy, output frame_done, output missed_tick);
`else
    modport master (output v_sync,
                    input ball_x, input ball_y, input busy, input frame_done, input missed_tick);
    modport slave  (input v_sync,
                    output ball_x, output ball_y, output busy, output frame_done, output missed_tick);
`endif
endinterface

// File: rtl/ball_motion.sv
// rtl/ball_motion.sv - per-frame ball position update with shadow registers and atomic commit (BALL_MOTION_PAUSE_EN adds pause)
module ball_motion #(
    parameter int NUM_BALLS     = 2,
    parameter int SCREEN_WIDTH  = 800,
    parameter int SCREEN_HEIGHT = 600,
    parameter int BALL_DIM      = 64,
    parameter int SPEED         = 5,
    parameter int START_X       = 150,
    parameter int START_Y       = 100,
    parameter int START_STEP    = 200
) (
    input  logic         clk_50mhz,
    input  logic         reset_n,
    ball_motion_if.slave bus
);
    localparam logic [9:0] MAX_X = 10'(SCREEN_WIDTH - BALL_DIM);
    localparam logic [9:0] MAX_Y = 10'(SCREEN_HEIGHT - BALL_DIM);
    localparam int         IDX_W = (NUM_BALLS > 1) ? $clog2(NUM_BALLS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_UPDATE, S_COMMIT} state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [IDX_W-1:0]        r_idx;
    logic                    r_vsync_q;
    logic [9:0]              r_sx [NUM_BALLS];
    logic [9:0]              r_sy [NUM_BALLS];
    logic                    r_vx [NUM_BALLS];
    logic                    r_vy [NUM_BALLS];
    logic [10*NUM_BALLS-1:0] r_ball_x;
    logic [10*NUM_BALLS-1:0] r_ball_y;
    logic                    w_tick;
    logic                    w_start;
    logic                    w_last;

    // Returns {new_dir, new_pos}; 11-bit math so pos+SPEED never wraps before the clamp test.
    function automatic logic [10:0] axis_step(input logic [9:0] pos, input logic dir,
                                              input logic [9:0] lim);
        logic [10:0] w_pos;
        w_pos = {1'b0, pos};
        if (dir && (w_pos + 11'(SPEED) >= {1'b0, lim}))
            return {1'b0, lim};
        else if (!dir && (w_pos <= 11'(SPEED)))
            return {1'b1, 10'd0};
        else if (dir)
            return {1'b1, 10'(w_pos + 11'(SPEED))};
        else
            return {1'b0, 10'(w_pos - 11'(SPEED))};
    endfunction

    assign w_tick = r_vsync_q & ~bus.v_sync;
    assign w_last = (r_idx == IDX_W'(NUM_BALLS - 1));
`ifdef BALL_MOTION_PAUSE_EN
    assign w_start = w_tick & ~bus.pause;
`else
    assign w_start = w_tick;
`endif

    always_ff @(posedge clk_50mhz or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_vsync_q <= 1'b1;
        end else begin
            r_state   <= w_next;
            r_vsync_q <= bus.v_sync;
        end
    end

    always_comb begin
        w_next          = r_state;
        bus.busy        = 1'b0;
        bus.frame_done  = 1'b0;
        bus.missed_tick = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start) w_next = S_UPDATE;
            end
            S_UPDATE: begin
                bus.busy        = 1'b1;
                bus.missed_tick = w_tick;
                if (w_last) w_next = S_COMMIT;
            end
            S_COMMIT: begin
                bus.busy        = 1'b1;
                bus.frame_done  = 1'b1;
                bus.missed_tick = w_tick;
                w_next          = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_50mhz or negedge reset_n) begin
        if (!reset_n) begin
            r_idx <= '0;
            for (int i = 0; i < NUM_BALLS; i++) begin
                r_sx[i]              <= 10'(START_X + i * START_STEP);
                r_sy[i]              <= 10'(START_Y);
                r_vx[i]              <= 1'b1;
                r_vy[i]              <= ((i % 2) == 0);
                r_ball_x[10*i +: 10] <= 10'(START_X + i * START_STEP);
                r_ball_y[10*i +: 10] <= 10'(START_Y);
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) r_idx <= '0;
                end
                S_UPDATE: begin
                    for (int i = 0; i < NUM_BALLS; i++) begin
                        if (r_idx == IDX_W'(i)) begin
                            {r_vx[i], r_sx[i]} <= axis_step(r_sx[i], r_vx[i], MAX_X);
                            {r_vy[i], r_sy[i]} <= axis_step(r_sy[i], r_vy[i], MAX_Y);
                        end
                    end
                    r_idx <= r_idx + IDX_W'(1);
                end
                S_COMMIT: begin
                    // Single-cycle commit keeps the lookup stages from seeing a half-updated set.
                    for (int i = 0; i < NUM_BALLS; i++) begin
                        r_ball_x[10*i +: 10] <= r_sx[i];
                        r_ball_y[10*i +: 10] <= r_sy[i];
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.ball_x = r_ball_x;
    assign bus.ball_y = r_ball_y;
endmodule

// File: tb/tb_ball_motion.sv
// tb/tb_ball_motion.sv - self-checking bench for ball_motion (BALL_MOTION_PAUSE_EN adds the pause sequence)
module tb_ball_motion;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    ball_motion_if #(.NUM_BALLS(2)) vif ();

    ball_motion #(.NUM_BALLS(2)) dut (
        .clk_50mhz (clk),
        .reset_n   (rst_n),
        .bus       (vif.slave)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [19:0] x;
        logic [19:0] y;
    } frame_t;

    typedef struct {
        int ticks;
        int b0x, b0y, b1x, b1y;
    } vec_t;

    frame_t sb_q[$];
    int     mx[2], my[2];
    bit     mvx[2], mvy[2];
    bit     pend = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            mx[i]  = 150 + 200 * i;
            my[i]  = 100;
            mvx[i] = 1'b1;
            mvy[i] = (i == 0);
        end
    endfunction

    function automatic void model_axis(inout int p, inout bit v, input int lim);
        if (v) begin
            p = p + 5;
            if (p >= lim) begin p = lim; v = 1'b0; end
        end else begin
            p = p - 5;
            if (p <= 0) begin p = 0; v = 1'b1; end
        end
    endfunction

    function automatic frame_t model_frame();
        frame_t f;
        for (int i = 0; i < 2; i++) begin
            f.x[10*i +: 10] = 10'(mx[i]);
            f.y[10*i +: 10] = 10'(my[i]);
        end
        return f;
    endfunction

    task automatic push_expected();
        for (int i = 0; i < 2; i++) begin
            model_axis(mx[i], mvx[i], 736);
            model_axis(my[i], mvy[i], 536);
        end
        sb_q.push_back(model_frame());
    endtask

    // Outputs move the cycle after frame_done, so compare one negedge later.
    always @(negedge clk) begin
        if (pend) begin
            pend = 1'b0;
            if (sb_q.size() == 0) begin
                check("unexpected_frame_done", 32'd1, 32'd0);
            end else begin
                frame_t e;
                e = sb_q.pop_front();
                check("sb_ball_x", 32'(vif.ball_x), 32'(e.x));
                check("sb_ball_y", 32'(vif.ball_y), 32'(e.y));
            end
        end
        if (vif.frame_done === 1'b1) pend = 1'b1;
    end

    task automatic do_tick(input bit timed);
        push_expected();
        @(negedge clk); vif.v_sync = 1'b0;
        @(negedge clk); vif.v_sync = 1'b1;
        if (timed) check("busy_T1", 32'(vif.busy), 32'd1);
        @(negedge clk);
        if (timed) check("frame_done_T2", 32'(vif.frame_done), 32'd0);
        @(negedge clk);
        if (timed) check("frame_done_T3", 32'(vif.frame_done), 32'd1);
        @(negedge clk);
        if (timed) begin
            check("busy_T4", 32'(vif.busy), 32'd0);
            check("frame_done_T4", 32'(vif.frame_done), 32'd0);
        end
    endtask

    initial begin
        vec_t tbl[8];
        int   done_ticks;
        tbl[0] = '{1,   155, 105, 355, 95};
        tbl[1] = '{19,  245, 195, 445, 5};
        tbl[2] = '{20,  250, 200, 450, 0};
        tbl[3] = '{21,  255, 205, 455, 5};
        tbl[4] = '{88,  590, 536, 686, 340};
        tbl[5] = '{89,  595, 531, 681, 345};
        tbl[6] = '{118, 736, 386, 536, 490};
        tbl[7] = '{119, 731, 381, 531, 495};

        vif.v_sync = 1'b1;
`ifdef BALL_MOTION_PAUSE_EN
        vif.pause = 1'b0;
`endif
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_ball_x", 32'(vif.ball_x), {12'd0, 10'd350, 10'd150});
        check("rst_ball_y", 32'(vif.ball_y), {12'd0, 10'd100, 10'd100});
        check("rst_busy", 32'(vif.busy), 32'd0);
        check("rst_frame_done", 32'(vif.frame_done), 32'd0);
        check("rst_missed_tick", 32'(vif.missed_tick), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        done_ticks = 0;
        for (int v = 0; v < 8; v++) begin
            while (done_ticks < tbl[v].ticks) begin
                do_tick(done_ticks < 2);
                done_ticks++;
            end
            check($sformatf("tbl%0d_b0x", v), 32'(vif.ball_x[9:0]),   32'(tbl[v].b0x));
            check($sformatf("tbl%0d_b0y", v), 32'(vif.ball_y[9:0]),   32'(tbl[v].b0y));
            check($sformatf("tbl%0d_b1x", v), 32'(vif.ball_x[19:10]), 32'(tbl[v].b1x));
            check($sformatf("tbl%0d_b1y", v), 32'(vif.ball_y[19:10]), 32'(tbl[v].b1y));
        end

        // Second falling edge lands while the first update is still running.
        push_expected();
        @(negedge clk); vif.v_sync = 1'b0;
        @(negedge clk); vif.v_sync = 1'b1;
        check("miss_busy", 32'(vif.busy), 32'd1);
        check("miss_no_pulse_yet", 32'(vif.missed_tick), 32'd0);
        @(negedge clk); vif.v_sync = 1'b0;
        #1 check("miss_pulse", 32'(vif.missed_tick), 32'd1);
        @(negedge clk); vif.v_sync = 1'b1;
        check("miss_frame_done", 32'(vif.frame_done), 32'd1);
        check("miss_pulse_gone", 32'(vif.missed_tick), 32'd0);
        repeat (6) begin
            @(negedge clk);
            check("miss_idle_after", 32'(vif.busy), 32'd0);
        end

        // Reset in the middle of an update discards the partial frame.
        @(negedge clk); vif.v_sync = 1'b0;
        @(negedge clk); vif.v_sync = 1'b1;
        @(negedge clk); rst_n = 1'b0;
        #1;
        check("midrst_ball_x", 32'(vif.ball_x), {12'd0, 10'd350, 10'd150});
        check("midrst_ball_y", 32'(vif.ball_y), {12'd0, 10'd100, 10'd100});
        check("midrst_busy", 32'(vif.busy), 32'd0);
        check("midrst_frame_done", 32'(vif.frame_done), 32'd0);
        repeat (3) begin
            @(negedge clk);
            check("midrst_no_frame_done", 32'(vif.frame_done), 32'd0);
        end
        rst_n = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        do_tick(1'b1);
        check("postrst_ball_x", 32'(vif.ball_x), {12'd0, 10'd355, 10'd155});
        check("postrst_ball_y", 32'(vif.ball_y), {12'd0, 10'd95, 10'd105});

`ifdef BALL_MOTION_PAUSE_EN
        vif.pause = 1'b1;
        repeat (5) begin
            @(negedge clk); vif.v_sync = 1'b0;
            #1 check("pause_no_missed", 32'(vif.missed_tick), 32'd0);
            @(negedge clk); vif.v_sync = 1'b1;
            check("pause_not_busy", 32'(vif.busy), 32'd0);
            repeat (3) @(negedge clk);
        end
        check("pause_ball_x", 32'(vif.ball_x), {12'd0, 10'd355, 10'd155});
        check("pause_ball_y", 32'(vif.ball_y), {12'd0, 10'd95, 10'd105});
        vif.pause = 1'b0;
`endif

        repeat (4) @(negedge clk);
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
